// File: rtl/vdp_super_res_vram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vdp_super_res_vram_arbiter_if : renderer, CPU and VRAM port signal bundle  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface vdp_super_res_vram_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              super_high_res;
  logic [1:0]        dot_phase;
  logic [ADDR_W-1:0] hr_addr;
  logic [31:0]       vrm_32;

  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Environment view: renderer, CPU and memory around the arbiter
  modport master (
    output super_high_res, dot_phase, hr_addr,
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  vrm_32, cpu_ack, cpu_rdata, cpu_rvalid,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    input  super_high_res, dot_phase, hr_addr,
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output vrm_32, cpu_ack, cpu_rdata, cpu_rvalid,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/vdp_super_res_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vdp_super_res_vram_arbiter : shares the VRAM port between the super-high-  |
// | res renderer (FS slot) and CPU accesses (DR slot, or any cycle when off).  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vdp_super_res_vram_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 17
) (
  input wire clk,
  input wire reset_n,
  vdp_super_res_vram_arbiter_if.slave bus
);

  localparam logic [1:0] PHASE_DR = 2'd1;
  localparam logic [1:0] PHASE_FS = 2'd3;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_CPU  = 2'd2
  } tag_t;

  tag_t              tag_pipe [MEM_LATENCY];
  logic [31:0]       disp_data;
  logic [31:0]       cpu_data;
  logic [31:0]       wdata_out;
  logic [ADDR_W-1:0] addr_out;
  logic              rd_strobe;
  logic              wr_strobe;
  logic              ack_pulse;
  logic              rvalid_pulse;

  logic              cpu_rd_pending;
  logic              disp_issue;
  logic              cpu_slot;
  logic              cpu_issue;

  always_comb begin
    cpu_rd_pending = 1'b0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      if (tag_pipe[i] == TAG_CPU) cpu_rd_pending = 1'b1;
    end
  end

  assign disp_issue = bus.super_high_res && (bus.dot_phase == PHASE_FS);
  assign cpu_slot   = bus.super_high_res ? (bus.dot_phase == PHASE_DR) : 1'b1;
  // ack_pulse high means the request still on the bus was just accepted
  assign cpu_issue  = cpu_slot && bus.cpu_req && !ack_pulse && !cpu_rd_pending;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      disp_data    <= '0;
      cpu_data     <= '0;
      wdata_out    <= '0;
      addr_out     <= '0;
      rd_strobe    <= 1'b0;
      wr_strobe    <= 1'b0;
      ack_pulse    <= 1'b0;
      rvalid_pulse <= 1'b0;
      for (int i = 0; i < MEM_LATENCY; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      rd_strobe    <= 1'b0;
      wr_strobe    <= 1'b0;
      ack_pulse    <= 1'b0;
      rvalid_pulse <= 1'b0;
      tag_pipe[0]  <= TAG_NONE;
      for (int i = 1; i < MEM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];

      if (disp_issue) begin
        addr_out    <= bus.hr_addr;
        rd_strobe   <= 1'b1;
        tag_pipe[0] <= TAG_DISP;
      end else if (cpu_issue) begin
        addr_out  <= bus.cpu_addr;
        ack_pulse <= 1'b1;
        if (bus.cpu_wr) begin
          wr_strobe <= 1'b1;
          wdata_out <= bus.cpu_wdata;
        end else begin
          rd_strobe   <= 1'b1;
          tag_pipe[0] <= TAG_CPU;
        end
      end

      // Returns keep flowing across mode changes; only reset drops them
      case (tag_pipe[MEM_LATENCY-1])
        TAG_DISP: disp_data <= bus.mem_rdata;
        TAG_CPU: begin
          cpu_data     <= bus.mem_rdata;
          rvalid_pulse <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.vrm_32     = disp_data;
  assign bus.cpu_rdata  = cpu_data;
  assign bus.cpu_rvalid = rvalid_pulse;
  assign bus.cpu_ack    = ack_pulse;
  assign bus.mem_addr   = addr_out;
  assign bus.mem_rd     = rd_strobe;
  assign bus.mem_wr     = wr_strobe;
  assign bus.mem_wdata  = wdata_out;

endmodule
`default_nettype wire

// File: tb/tb_vdp_super_res_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vdp_super_res_vram_arbiter : scoreboard bench for the VRAM arbiter      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vdp_super_res_vram_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  vdp_super_res_vram_arbiter_if #(.ADDR_W(17)) bus ();

  vdp_super_res_vram_arbiter #(.MEM_LATENCY(2), .ADDR_W(17)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [16:0] addr; logic [31:0] due; } disp_t;
  typedef struct packed { logic [31:0] data; logic [31:0] due; } data_t;
  typedef struct packed {
    logic        wr;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        chk_phase;
    logic [1:0]  phase;
  } cpu_t;

  disp_t disp_q[$];
  data_t vrm_q[$];
  cpu_t  cpu_q[$];
  data_t rv_q[$];
  logic [31:0] mem [logic [16:0]];

  function automatic logic [31:0] preset(input logic [16:0] a);
    case (a)
      17'h00010: preset = 32'h00A1B2C3;
      17'h00400: preset = 32'h12345678;
      default:   preset = 32'h5A5A0000 ^ {15'h0, a};
    endcase
  endfunction

  function automatic logic [31:0] rd_val(input logic [16:0] a);
    if (mem.exists(a)) return mem[a];
    return preset(a);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // VRAM model: data appears in the cycle after the strobe cycle
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata <= bus.mem_rd ? rd_val(bus.mem_addr) : 32'hBAD0BAD0;
  end

  // Display predictor: FS decision -> strobe next cycle -> vrm_32 valid 3 cycles on
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n === 1'b1 && bus.super_high_res === 1'b1 && bus.dot_phase == 2'd3) begin
      disp_q.push_back({bus.hr_addr, 32'(cyc + 1)});
      vrm_q.push_back({preset(bus.hr_addr), 32'(cyc + 3)});
    end
  end

  initial begin
    bus.dot_phase = 2'd0;
    forever begin
      @(posedge clk);
      #1 bus.dot_phase = bus.dot_phase + 2'd1;
    end
  end

  // Monitor: return data first, then issue strobes, then renderer data
  always @(negedge clk) begin
    disp_t de;
    cpu_t  ce;
    data_t re;
    data_t ve;
    if (bus.cpu_rvalid === 1'b1) begin
      if (rv_q.size() == 0) chk("rvalid_unexpected", 128'(bus.cpu_rvalid), 128'(0));
      else begin
        re = rv_q.pop_front();
        chk("cpu_rdata", 128'(bus.cpu_rdata), 128'(re.data));
        chk("rvalid_cycle", 128'(cyc), 128'(re.due));
      end
    end
    if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) chk("strobe_exclusive", 128'(2'b11), 128'(2'b10));
    if (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1) begin
      if (bus.cpu_ack === 1'b1) begin
        if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 128'(bus.cpu_ack), 128'(0));
        else begin
          ce = cpu_q.pop_front();
          chk("cpu_strobe", 128'({bus.mem_rd, bus.mem_wr}), 128'(ce.wr ? 2'b01 : 2'b10));
          chk("cpu_addr", 128'(bus.mem_addr), 128'(ce.addr));
          if (ce.wr) chk("cpu_wdata", 128'(bus.mem_wdata), 128'(ce.wdata));
          if (ce.chk_phase) chk("cpu_phase", 128'(bus.dot_phase), 128'(ce.phase));
          if (!ce.wr) begin
            chk("one_outstanding", 128'(rv_q.size()), 128'(0));
            rv_q.push_back({ce.rdata, 32'(cyc + 2)});
          end
        end
      end else begin
        if (disp_q.size() == 0) chk("disp_unexpected", 128'(bus.mem_addr), 128'h1_0000_0000);
        else begin
          de = disp_q.pop_front();
          chk("disp_addr", 128'(bus.mem_addr), 128'(de.addr));
          chk("disp_strobe", 128'({bus.mem_rd, bus.mem_wr}), 128'(2'b10));
          chk("disp_cycle", 128'(cyc), 128'(de.due));
          chk("disp_phase", 128'(bus.dot_phase), 128'(2'd0));
        end
      end
    end else if (bus.cpu_ack === 1'b1) begin
      chk("ack_without_strobe", 128'(bus.cpu_ack), 128'(0));
    end
    if (vrm_q.size() > 0 && vrm_q[0].due == 32'(cyc)) begin
      ve = vrm_q.pop_front();
      chk("vrm_32", 128'(bus.vrm_32), 128'(ve.data));
    end
  end

  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.dot_phase == p) break;
    end
  endtask

  task automatic cpu_access(input logic wr, input logic [16:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input logic chk_ph, input logic keep_req);
    cpu_t e;
    e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd; e.chk_phase = chk_ph; e.phase = 2'd2;
    cpu_q.push_back(e);
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) break;
    end
    chk("cpu_ack_seen", 128'(bus.cpu_ack), 128'(1));
    if (!keep_req) bus.cpu_req = 1'b0;
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({bus.vrm_32, bus.cpu_ack, bus.cpu_rdata, bus.cpu_rvalid,
                 bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.mem_wdata});
  endfunction

  initial begin
    reset_n            = 1'b0;
    bus.super_high_res = 1'b1;
    bus.hr_addr        = 17'h00022;
    bus.cpu_req        = 1'b1;
    bus.cpu_wr         = 1'b0;
    bus.cpu_addr       = 17'h00400;
    bus.cpu_wdata      = 32'h0;

    // Reset held with requests pending
    repeat (5) @(negedge clk);
    chk("reset_outputs", all_outputs(), 128'(0));
    bus.cpu_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Display slots at two renderer addresses
    repeat (10) @(negedge clk);
    bus.hr_addr = 17'h00010;
    repeat (12) @(negedge clk);

    // CPU write presented at FS must wait for DR
    wait_phase(2'd3);
    cpu_access(1'b1, 17'h1FFFE, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);

    // CPU reads interleaved with display reads
    cpu_access(1'b0, 17'h00400, 32'h0, 32'h12345678, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    cpu_access(1'b0, 17'h1FFFE, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    repeat (6) @(negedge clk);

    // Drop super-high-res with a display read in flight
    wait_phase(2'd2);
    bus.hr_addr = 17'h00030;
    wait_phase(2'd0);
    bus.super_high_res = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back CPU reads with request held high
    cpu_access(1'b0, 17'h00400, 32'h0, 32'h12345678, 1'b0, 1'b1);
    cpu_access(1'b0, 17'h00010, 32'h0, 32'h00A1B2C3, 1'b0, 1'b1);
    cpu_access(1'b0, 17'h1FFFE, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    cpu_access(1'b1, 17'h00500, 32'h0BADF00D, 32'h0, 1'b0, 1'b0);
    cpu_access(1'b0, 17'h00500, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    chk("vrm_hold", 128'(bus.vrm_32), 128'(32'h5A5A0030));

    // Reset one cycle after a CPU read issues
    cpu_access(1'b0, 17'h00400, 32'h0, 32'h12345678, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    rv_q.delete();
    repeat (3) @(negedge clk);
    chk("reset_mid_read", all_outputs(), 128'(0));
    reset_n = 1'b1;
    @(negedge clk);
    cpu_access(1'b0, 17'h00400, 32'h0, 32'h12345678, 1'b0, 1'b0);
    repeat (6) @(negedge clk);

    chk("drain_disp", 128'(disp_q.size()), 128'(0));
    chk("drain_vrm", 128'(vrm_q.size()), 128'(0));
    chk("drain_cpu", 128'(cpu_q.size()), 128'(0));
    chk("drain_rvalid", 128'(rv_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
